// File: rtl/csc_sched_pkg.sv
// csc_sched_pkg: shared encodings for the CSC ping-pong group scheduler
// Contents:
//   ST_IDLE/ST_RUNNING/ST_PENDING - software-visible per-group status codes
//   fsm_t                         - top scheduler states S_IDLE/S_RUN/S_GAP
//   GRP0/GRP1                     - group index constants
package csc_sched_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } fsm_t;
  localparam logic GRP0 = 1'b0;
  localparam logic GRP1 = 1'b1;
endpackage

// File: rtl/csc_group_state.sv
// csc_group_state: per-group IDLE/PENDING/RUNNING tracker for one register group
// Ports:
//   nvdla_core_clk, nvdla_core_rstn - clock, async active-low reset
//   set    - software OP_ENABLE pulse for this group
//   launch - scheduler starts this group (only issued while PENDING)
//   done   - datapath finished this group (only issued while RUNNING)
//   status - registered status code
//   reject - combinational: set arrived while the group was not IDLE
module csc_group_state
  import csc_sched_pkg::*;
(
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       set,
  input  logic       launch,
  input  logic       done,
  output logic [1:0] status,
  output logic       reject
);
  logic [1:0] status_nxt;
  // done has priority so a set landing on the final running cycle cannot re-pend the group
  always_comb begin
    reject     = set && (status != ST_IDLE);
    status_nxt = done ? ST_IDLE :
                 launch ? ST_RUNNING :
                 (set && status == ST_IDLE) ? ST_PENDING : status;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) status <= ST_IDLE;
    else                  status <= status_nxt;
  end
endmodule

// File: rtl/csc_group_scheduler.sv
// csc_group_scheduler: launches the two CSC register groups in strict alternating order
// Ports:
//   nvdla_core_clk, nvdla_core_rstn - clock, async active-low reset
//   op_en_set[1:0] - per-group OP_ENABLE write pulses
//   dp_done        - datapath finished the running layer
//   dp_op_en       - datapath run level
//   dp_group       - group being executed (same as consumer)
//   consumer       - next/current group to execute
//   status_0/1     - per-group status (0 idle, 1 running, 2 pending)
//   group_busy     - per-group write-protect (status != idle)
//   done_intr      - per-group completion pulse
//   err_pulse      - protocol violation pulse
module csc_group_scheduler
  import csc_sched_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int GAP_W      = 4
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic [1:0] op_en_set,
  input  logic       dp_done,
  output logic       dp_op_en,
  output logic       dp_group,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] group_busy,
  output logic [1:0] done_intr,
  output logic       err_pulse
);
  fsm_t             state, state_nxt;
  logic [GAP_W-1:0] cnt, cnt_nxt;
  logic             consumer_nxt, dp_op_en_nxt, err_nxt;
  logic [1:0]       launch, done, reject, cur_sel;
  logic [1:0]       cur_st;
  csc_group_state u_grp0 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .set            (op_en_set[GRP0]),
    .launch         (launch[GRP0]),
    .done           (done[GRP0]),
    .status         (status_0),
    .reject         (reject[GRP0])
  );
  csc_group_state u_grp1 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .set            (op_en_set[GRP1]),
    .launch         (launch[GRP1]),
    .done           (done[GRP1]),
    .status         (status_1),
    .reject         (reject[GRP1])
  );
  assign dp_group   = consumer;
  assign group_busy = {status_1 != ST_IDLE, status_0 != ST_IDLE};
  // Only the consumer's status matters; a pending non-consumer group must wait its turn
  always_comb begin
    cur_sel      = consumer ? 2'b10 : 2'b01;
    cur_st       = consumer ? status_1 : status_0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    consumer_nxt = consumer;
    dp_op_en_nxt = dp_op_en;
    launch       = 2'b00;
    done         = 2'b00;
    case (state)
      S_IDLE: if (cur_st == ST_PENDING) begin
        launch       = cur_sel;
        dp_op_en_nxt = 1'b1;
        state_nxt    = S_RUN;
      end
      S_RUN: if (dp_done) begin
        done         = cur_sel;
        dp_op_en_nxt = 1'b0;
        consumer_nxt = ~consumer;
        cnt_nxt      = GAP_W'(GAP_CYCLES);
        state_nxt    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        cnt_nxt   = cnt - GAP_W'(1);
        state_nxt = (cnt <= GAP_W'(1)) ? S_IDLE : S_GAP;
      end
      default: state_nxt = S_IDLE;
    endcase
    err_nxt = (|reject) || (dp_done && state != S_RUN);
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      consumer  <= GRP0;
      dp_op_en  <= 1'b0;
      done_intr <= 2'b00;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      consumer  <= consumer_nxt;
      dp_op_en  <= dp_op_en_nxt;
      done_intr <= done;
      err_pulse <= err_nxt;
    end
  end
endmodule

// File: tb/tb_csc_group_scheduler.sv
// tb_csc_group_scheduler: directed self-checking bench for csc_group_scheduler
module tb_csc_group_scheduler;
  logic       clk;
  logic       rstn;
  logic [1:0] op_en_set;
  logic       dp_done;
  logic       dp_op_en, dp_group, consumer, err_pulse;
  logic [1:0] status_0, status_1, group_busy, done_intr;
  int checks = 0;
  int errors = 0;
  csc_group_scheduler #(.GAP_CYCLES(4), .GAP_W(4)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .op_en_set      (op_en_set),
    .dp_done        (dp_done),
    .dp_op_en       (dp_op_en),
    .dp_group       (dp_group),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .group_busy     (group_busy),
    .done_intr      (done_intr),
    .err_pulse      (err_pulse)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [1:0] s, input logic d);
    op_en_set = s;
    dp_done   = d;
    step();
    op_en_set = 2'b00;
    dp_done   = 1'b0;
  endtask
  task automatic do_reset();
    rstn      = 1'b0;
    op_en_set = 2'b00;
    dp_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({dp_op_en, dp_group, consumer, status_0, status_1, group_busy, done_intr, err_pulse} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %03h want 000",
               {dp_op_en, dp_group, consumer, status_0, status_1, group_busy, done_intr, err_pulse});
    end
  endtask
  task automatic test_basic();
    do_reset();
    pulse(2'b01, 1'b0);
    checks++;
    if (status_0 !== 2'd2) begin errors++; $display("FAIL basic_pending: status_0 got %0d want 2", status_0); end
    step();
    checks++;
    if ({dp_op_en, status_0, consumer, group_busy} !== {1'b1, 2'd1, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL basic_launch: dp_op_en/status_0/consumer/busy got %b %0d %b %b want 1 1 0 01",
               dp_op_en, status_0, consumer, group_busy);
    end
    repeat (7) step();
    pulse(2'b00, 1'b1);
    checks++;
    if ({done_intr, status_0, consumer, dp_op_en} !== {2'b01, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_done: done_intr/status_0/consumer/dp_op_en got %b %0d %b %b want 01 0 1 0",
               done_intr, status_0, consumer, dp_op_en);
    end
    step();
    checks++;
    if (done_intr !== 2'b00) begin errors++; $display("FAIL basic_done_pulse: done_intr got %b want 00", done_intr); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    pulse(2'b11, 1'b0);
    checks++;
    if ({status_0, status_1} !== {2'd2, 2'd2}) begin
      errors++;
      $display("FAIL b2b_pending: status got %0d %0d want 2 2", status_0, status_1);
    end
    step();
    checks++;
    if ({dp_op_en, dp_group, status_0, status_1} !== {1'b1, 1'b0, 2'd1, 2'd2}) begin
      errors++;
      $display("FAIL b2b_first: dp_op_en/dp_group/status got %b %b %0d %0d want 1 0 1 2",
               dp_op_en, dp_group, status_0, status_1);
    end
    repeat (3) step();
    pulse(2'b00, 1'b1);
    checks++;
    if ({done_intr, consumer, dp_op_en, status_1} !== {2'b01, 1'b1, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL b2b_done0: done_intr/consumer/dp_op_en/status_1 got %b %b %b %0d want 01 1 0 2",
               done_intr, consumer, dp_op_en, status_1);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      checks++;
      if ({dp_op_en, status_1} !== {1'b0, 2'd2}) begin
        errors++;
        $display("FAIL b2b_gap: cycle %0d dp_op_en/status_1 got %b %0d want 0 2", k, dp_op_en, status_1);
      end
    end
    step();
    checks++;
    if ({dp_op_en, dp_group, status_1} !== {1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL b2b_second: dp_op_en/dp_group/status_1 got %b %b %0d want 1 1 1", dp_op_en, dp_group, status_1);
    end
    step();
    pulse(2'b00, 1'b1);
    checks++;
    if ({done_intr, consumer, status_1} !== {2'b10, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL b2b_done1: done_intr/consumer/status_1 got %b %b %0d want 10 0 0", done_intr, consumer, status_1);
    end
  endtask
  task automatic test_order();
    do_reset();
    pulse(2'b10, 1'b0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({dp_op_en, status_1, status_0, consumer} !== {1'b0, 2'd2, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL order_hold: cycle %0d dp_op_en/status_1/status_0/consumer got %b %0d %0d %b want 0 2 0 0",
                 k, dp_op_en, status_1, status_0, consumer);
      end
      step();
    end
  endtask
  task automatic test_errors();
    do_reset();
    pulse(2'b01, 1'b0);
    step();
    pulse(2'b01, 1'b0);
    checks++;
    if ({err_pulse, status_0, consumer, dp_op_en} !== {1'b1, 2'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL err_set_running: err/status_0/consumer/dp_op_en got %b %0d %b %b want 1 1 0 1",
               err_pulse, status_0, consumer, dp_op_en);
    end
    step();
    checks++;
    if ({err_pulse, status_0} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL err_pulse_width: err/status_0 got %b %0d want 0 1", err_pulse, status_0);
    end
    pulse(2'b00, 1'b1);
    repeat (4) step();
    pulse(2'b00, 1'b1);
    checks++;
    if ({err_pulse, consumer, status_0, status_1, done_intr, dp_op_en} !== {1'b1, 1'b1, 2'd0, 2'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL err_done_idle: err/consumer/status/done_intr/dp_op_en got %b %b %0d %0d %b %b want 1 1 0 0 00 0",
               err_pulse, consumer, status_0, status_1, done_intr, dp_op_en);
    end
    step();
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL err_idle_clear: err got %b want 0", err_pulse); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    pulse(2'b01, 1'b0);
    step();
    pulse(2'b01, 1'b1);
    checks++;
    if ({status_0, err_pulse, done_intr} !== {2'd0, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL sim_same: status_0/err/done_intr got %0d %b %b want 0 1 01", status_0, err_pulse, done_intr);
    end
    repeat (10) step();
    checks++;
    if ({status_0, dp_op_en} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL sim_same_no_repend: status_0/dp_op_en got %0d %b want 0 0", status_0, dp_op_en);
    end
    do_reset();
    pulse(2'b01, 1'b0);
    step();
    pulse(2'b10, 1'b1);
    checks++;
    if ({status_0, status_1, err_pulse, consumer} !== {2'd0, 2'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sim_other: status_0/status_1/err/consumer got %0d %0d %b %b want 0 2 0 1",
               status_0, status_1, err_pulse, consumer);
    end
    repeat (4) step();
    checks++;
    if (dp_op_en !== 1'b0) begin errors++; $display("FAIL sim_other_gap: dp_op_en got %b want 0", dp_op_en); end
    step();
    checks++;
    if ({dp_op_en, dp_group, status_1} !== {1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL sim_other_launch: dp_op_en/dp_group/status_1 got %b %b %0d want 1 1 1", dp_op_en, dp_group, status_1);
    end
  endtask
  task automatic test_reset_mid_run();
    do_reset();
    pulse(2'b01, 1'b0);
    step();
    step();
    rstn = 1'b0;
    #1;
    checks++;
    if ({dp_op_en, consumer, status_0, status_1, group_busy, done_intr, err_pulse} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid_run: outputs got %03h want 000",
               {dp_op_en, consumer, status_0, status_1, group_busy, done_intr, err_pulse});
    end
    step();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({done_intr, dp_op_en, status_0} !== {2'b00, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d done_intr/dp_op_en/status_0 got %b %b %0d want 00 0 0",
                 k, done_intr, dp_op_en, status_0);
      end
    end
  endtask
  initial begin
    rstn      = 1'b0;
    op_en_set = 2'b00;
    dp_done   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_order();
    test_errors();
    test_simultaneous();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
